// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle RV64 main control FSM.
package control_pkg;

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;
  localparam logic [1:0] ALU_IFN = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BOFF = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/control_mem_watchdog.sv
// Counts consecutive stalled memory cycles; fire marks the LIMIT-th stalled cycle.
// LIMIT = 0 disables the watchdog entirely.
module control_mem_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic fire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Stall counter next value and limit compare; a ready cycle always clears.
  always_comb begin
    cnt_d = '0;
    fire  = 1'b0;
    if (LIMIT == 0) begin
      cnt_d = '0;
      fire  = 1'b0;
    end else if (active && !ready) begin
      if (cnt_q == CW'(LIMIT - 1)) begin
        fire  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV64 main control FSM with memory watchdog and retire counter.
// Optional: CONTROL_ILLEGAL_TRAP_EN traps on illegal opcodes instead of retiring them as NOPs.
module multicycle_control
  import control_pkg::*;
#(
  parameter int RETIRE_CNT_W    = 32,
  parameter int MEM_TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode,
  input  logic                    mem_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    i_or_d,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    pc_source,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic                    mem_to_reg,
  output logic                    reg_write,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] retire_cnt,
  output logic                    halted,
  output logic                    mem_timeout,
  output logic                    illegal_op,
  output logic [3:0]              state
);

  state_t                  state_q, state_d;
  logic [RETIRE_CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic                    mem_timeout_q, mem_timeout_d;
  logic                    wd_active, wd_fire;

  assign wd_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  control_mem_watchdog #(.LIMIT(MEM_TIMEOUT_CYC)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (wd_active),
    .ready  (mem_ready),
    .fire   (wd_fire)
  );

  // Next-state and Moore control decode; only fetch strobes and store retire see mem_ready.
  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_d = S_DECODE;
        else if (wd_fire) state_d = S_TRAP;
        else              state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRC_B_BOFF;
        case (opcode)
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_R, OP_I:   state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        if (opcode == OP_LD) state_d = S_MEM_RD;
        else                 state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_d = S_MEM_WB;
        else if (wd_fire) state_d = S_TRAP;
        else              state_d = S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
        if (mem_ready)    state_d = S_FETCH;
        else if (wd_fire) state_d = S_TRAP;
        else              state_d = S_MEM_WR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (opcode == OP_R) begin
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_RFN;
        end else begin
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_IFN;
        end
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: begin
        halted  = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Retire counter and sticky watchdog flag next values.
  always_comb begin
    if (retire) retire_cnt_d = retire_cnt_q + RETIRE_CNT_W'(1);
    else        retire_cnt_d = retire_cnt_q;
    mem_timeout_d = mem_timeout_q | wd_fire;
  end

  // State, counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      retire_cnt_q  <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      retire_cnt_q  <= retire_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic illegal_op_q, illegal_op_d;

  // Sticky illegal-opcode flag, set when DECODE sees an unknown opcode.
  always_comb begin
    if (state_q == S_DECODE && !is_legal(opcode)) illegal_op_d = 1'b1;
    else                                          illegal_op_d = illegal_op_q;
  end

  // Illegal-opcode flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_op_q <= 1'b0;
    else        illegal_op_q <= illegal_op_d;
  end

  assign illegal_op = illegal_op_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign retire_cnt  = retire_cnt_q;
  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction mix against a latency/effect model.
module tb_multicycle_control;
  import control_pkg::*;

  localparam int CNT_W = 3;
  localparam int TO    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = 7'd0;
  logic             mem_ready = 1'b0;
  logic             mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic             pc_source, alu_src_a, mem_to_reg, reg_write, retire;
  logic [1:0]       alu_src_b, alu_op;
  logic [CNT_W-1:0] retire_cnt;
  logic             halted, mem_timeout, illegal_op;
  logic [3:0]       state;

  multicycle_control #(.RETIRE_CNT_W(CNT_W), .MEM_TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
    .retire_cnt(retire_cnt), .halted(halted), .mem_timeout(mem_timeout),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] op; int wf; int wm; } plan_t;
  typedef struct { int lat; int n_rw; int n_pwc; int n_sub; logic m2r; logic mw; } exp_t;

  plan_t plan_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    failures = 0;

  wire [14:0] ctrl_vec = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                          pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, retire};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit retires(input logic [6:0] op);
`ifdef CONTROL_ILLEGAL_TRAP_EN
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
`else
    return 1'b1;
`endif
  endfunction

  // Reference: cycles FETCH-to-retire and per-instruction effects from the instruction class.
  function automatic exp_t predict(input plan_t p);
    exp_t e;
    e.lat = 2 + p.wf; e.n_rw = 0; e.n_pwc = 0; e.n_sub = 0; e.m2r = 1'b0; e.mw = 1'b0;
    if (p.op == OP_R || p.op == OP_I) begin
      e.lat = 4 + p.wf; e.n_rw = 1;
    end else if (p.op == OP_LD) begin
      e.lat = 5 + p.wf + p.wm; e.n_rw = 1; e.m2r = 1'b1;
    end else if (p.op == OP_SD) begin
      e.lat = 4 + p.wf + p.wm; e.mw = 1'b1;
    end else if (p.op == OP_BEQ) begin
      e.lat = 3 + p.wf; e.n_pwc = 1; e.n_sub = 1;
    end
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input int wf, input int wm);
    plan_t p;
    p.op = op; p.wf = wf; p.wm = wm;
    plan_q.push_back(p);
    if (retires(op)) sb_q.push_back(predict(p));
  endtask

  // Memory responder: serves fetches from the plan, inserting the planned wait cycles.
  initial begin : responder
    plan_t cur;
    int    wl;
    bit    fbusy, dbusy;
    wl = 0; fbusy = 1'b0; dbusy = 1'b0;
    cur.op = 7'd0; cur.wf = 0; cur.wm = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fbusy = 1'b0; dbusy = 1'b0; mem_ready = 1'b0;
      end else if (mem_read && !i_or_d) begin
        if (!fbusy && plan_q.size() != 0) begin
          cur = plan_q.pop_front();
          opcode = cur.op; wl = cur.wf; fbusy = 1'b1;
        end
        if (!fbusy) mem_ready = 1'b0;
        else if (wl > 0) begin mem_ready = 1'b0; wl--; end
        else begin mem_ready = 1'b1; fbusy = 1'b0; end
      end else if (mem_read || mem_write) begin
        if (!dbusy) begin wl = cur.wm; dbusy = 1'b1; end
        if (wl > 0) begin mem_ready = 1'b0; wl--; end
        else begin mem_ready = 1'b1; dbusy = 1'b0; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: accumulates per-instruction activity and checks it on each retire pulse.
  initial begin : monitor
    int   lat, nrw, npwc, nsub, nirw, npcw, exp_cnt;
    bit   skip;
    exp_t e;
    lat = 0; nrw = 0; npwc = 0; nsub = 0; nirw = 0; npcw = 0; exp_cnt = 0; skip = 1'b1;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        sb_q.delete();
        exp_cnt = 0; skip = 1'b1;
        lat = 0; nrw = 0; npwc = 0; nsub = 0; nirw = 0; npcw = 0;
      end else if (skip) begin
        skip = 1'b0;
      end else begin
        lat++;
        nrw += int'(reg_write); npwc += int'(pc_write_cond);
        nsub += int'(alu_op == ALU_SUB); nirw += int'(ir_write); npcw += int'(pc_write);
        if (retire) begin
          if (sb_q.size() == 0) begin
            chk("retire_unexpected", retire, 1'b0);
          end else begin
            e = sb_q.pop_front();
            chk("latency", lat, e.lat);
            chk("reg_write_cycles", nrw, e.n_rw);
            chk("pc_write_cond_cycles", npwc, e.n_pwc);
            chk("alu_sub_cycles", nsub, e.n_sub);
            chk("ir_write_cycles", nirw, 1);
            chk("pc_write_cycles", npcw, 1);
            chk("mem_to_reg_at_retire", mem_to_reg, e.m2r);
            chk("mem_write_at_retire", mem_write, e.mw);
            chk("retire_cnt_at_retire", retire_cnt, exp_cnt % (1 << CNT_W));
            exp_cnt++;
          end
          lat = 0; nrw = 0; npwc = 0; nsub = 0; nirw = 0; npcw = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    plan_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int exp_total);
    int t;
    t = 0;
    @(negedge clk);
    while (sb_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", sb_q.size(), 0);
    #2;
    chk("retire_cnt_final", retire_cnt, exp_total % (1 << CNT_W));
  endtask

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "bench time limit");
  end

  initial begin : main
    state_t     trace[4];
    logic [6:0] ops[7];
    int         n, nops, k;
    trace[0] = S_FETCH; trace[1] = S_DECODE; trace[2] = S_EXEC; trace[3] = S_ALU_WB;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_SD; ops[4] = OP_BEQ;
    ops[5] = 7'b1111111; ops[6] = 7'b0000000;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    nops = 5;
`else
    nops = 7;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("reset_state", state, S_INIT);
    chk("reset_ctrl", ctrl_vec, 15'd0);
    chk("reset_flags", {halted, mem_timeout, illegal_op}, 3'd0);
    chk("reset_retire_cnt", retire_cnt, 0);

    // R instruction, zero-wait: INIT, FETCH, DECODE, EXEC, ALU_WB
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_R, 0, 0);
    #2 chk("trace_r_init", state, S_INIT);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("trace_r", state, trace[i]);
    end
    drain(1);

    // LD with stalled fetch at the watchdog boundary and 3 MEM_RD waits, then SD/BEQ/I
    do_reset();
    issue(OP_LD, 3, 3);
    issue(OP_SD, 0, 0);
    issue(OP_BEQ, 0, 0);
    issue(OP_I, 0, 2);
    drain(4);

    // Exactly 8 retires wrap the 3-bit counter back to 0
    do_reset();
    for (int i = 0; i < 8; i++) issue(OP_BEQ, 0, 0);
    drain(8);

    // Random instruction mix with random memory waits below the watchdog limit
    do_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, nops - 1);
      issue(ops[k], $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
      if (retires(ops[k])) n++;
    end
    drain(n);

    // Watchdog: fetch never completes
    do_reset();
    for (int i = 0; i < TO; i++) begin
      @(negedge clk); #2;
      chk("wd_fetch_state", state, S_FETCH);
      chk("wd_no_timeout_yet", mem_timeout, 1'b0);
    end
    repeat (3) begin
      @(negedge clk); #2;
      chk("wd_trap_state", state, S_TRAP);
      chk("wd_flags", {halted, mem_timeout}, 2'b11);
      chk("wd_ctrl_zero", ctrl_vec, 15'd0);
    end

    // Illegal opcode
    do_reset();
`ifdef CONTROL_ILLEGAL_TRAP_EN
    issue(7'b1111111, 0, 0);
    repeat (2) @(negedge clk);
    repeat (2) begin
      @(negedge clk); #2;
      chk("illegal_trap_state", state, S_TRAP);
      chk("illegal_flags", {halted, illegal_op, mem_timeout}, 3'b110);
      chk("illegal_ctrl_zero", ctrl_vec, 15'd0);
    end
`else
    issue(7'b1111111, 0, 0);
    issue(OP_R, 1, 0);
    drain(2);
    chk("illegal_op_tied", illegal_op, 1'b0);
`endif

    // Reset in the middle of a stalled store aborts it with no retire
    do_reset();
    issue(OP_SD, 0, 3);
    k = 0;
    while (k < 20 && state != S_MEM_WR) begin
      @(negedge clk); #2;
      k++;
    end
    chk("reached_mem_wr", state, S_MEM_WR);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_state", state, S_INIT);
    chk("abort_retire", retire, 1'b0);
    chk("abort_retire_cnt", retire_cnt, 0);
    do_reset();
    issue(OP_R, 0, 0);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
